// File: rtl/generateproof_hls_deadlock_reporter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : generateproof_hls_deadlock_reporter                           |
// | Purpose  : confirms persistent monitor blocks, snapshots the block/idle  |
// |            vectors and hands one report over valid/ready.                |
// | Option   : GENERATEPROOF_DEADLOCK_TIMESTAMP_EN adds rpt_timestamp.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module generateproof_hls_deadlock_reporter #(
   parameter int NUM_MON        = 2,
   parameter int AXIS_W         = 8,
   parameter int IDLE_W         = 19,
   parameter int BLOCK_W        = 11,
   parameter int CONFIRM_CYCLES = 16,
   parameter int TS_W           = 32,
   localparam int ID_W          = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_MON-1:0] mon_block,
   input  logic [AXIS_W-1:0]  axis_block_sigs,
   input  logic [IDLE_W-1:0]  inst_idle_sigs,
   input  logic [BLOCK_W-1:0] inst_block_sigs,
   input  logic               clear,
   output logic               rpt_valid,
   input  logic               rpt_ready,
   output logic [ID_W-1:0]    rpt_mon_id,
   output logic [AXIS_W-1:0]  rpt_axis,
   output logic [IDLE_W-1:0]  rpt_idle,
   output logic [BLOCK_W-1:0] rpt_inst_block,
   output logic [15:0]        rpt_count,
`ifdef GENERATEPROOF_DEADLOCK_TIMESTAMP_EN
   output logic [TS_W-1:0]    rpt_timestamp,
`endif
   output logic               deadlock_flag
);

   localparam logic [15:0] C_LAST    = 16'(CONFIRM_CYCLES - 1);
   localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_CONFIRM = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t             r_state;
   logic [15:0]        r_cnt;
   logic [ID_W-1:0]    r_cand_id;
   logic               r_valid;
   logic [ID_W-1:0]    r_mon_id;
   logic [AXIS_W-1:0]  r_axis;
   logic [IDLE_W-1:0]  r_idle;
   logic [BLOCK_W-1:0] r_inst_block;
   logic [15:0]        r_rpt_count;
   logic               r_flag;

   logic               w_any;
   logic               w_cand_hi;
   logic [ID_W-1:0]    w_low_id;

   assign w_any     = |mon_block;
   assign w_cand_hi = mon_block[r_cand_id];

   // Descending scan so the lowest set index is the final winner.
   always_comb begin
      w_low_id = '0;
      for (int i = NUM_MON - 1; i >= 0; i--) begin
         if (mon_block[i]) w_low_id = ID_W'(i);
      end
   end

`ifdef GENERATEPROOF_DEADLOCK_TIMESTAMP_EN
   logic [TS_W-1:0] r_ts;
   logic [TS_W-1:0] r_ts_snap;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ts      <= '0;
         r_ts_snap <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (r_state == S_ARM && !clear && w_cand_hi && r_cnt == C_LAST)
            r_ts_snap <= r_ts;
      end
   end

   assign rpt_timestamp = r_ts_snap;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_cand_id    <= '0;
         r_valid      <= 1'b0;
         r_mon_id     <= '0;
         r_axis       <= '0;
         r_idle       <= '0;
         r_inst_block <= '0;
         r_rpt_count  <= '0;
         r_flag       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (clear) begin
                  r_flag <= 1'b0;
                  r_cnt  <= '0;
               end else if (w_any) begin
                  r_cand_id <= w_low_id;
                  r_cnt     <= 16'd1;
                  r_state   <= S_ARM;
               end
            end
            S_ARM: begin
               if (clear) begin
                  r_flag  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else if (!w_cand_hi) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else if (r_cnt == C_LAST) begin
                  r_axis       <= axis_block_sigs;
                  r_idle       <= inst_idle_sigs;
                  r_inst_block <= inst_block_sigs;
                  r_mon_id     <= r_cand_id;
                  r_flag       <= 1'b1;
                  r_valid      <= 1'b1;
                  r_cnt        <= '0;
                  r_state      <= S_CONFIRM;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            // A pending report is never dropped: clear and monitors are ignored.
            S_CONFIRM: begin
               if (rpt_ready) begin
                  r_valid <= 1'b0;
                  if (r_rpt_count != C_CNT_MAX) r_rpt_count <= r_rpt_count + 16'd1;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (clear) begin
                  r_flag  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else if (!w_any) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rpt_valid      = r_valid;
   assign rpt_mon_id     = r_mon_id;
   assign rpt_axis       = r_axis;
   assign rpt_idle       = r_idle;
   assign rpt_inst_block = r_inst_block;
   assign rpt_count      = r_rpt_count;
   assign deadlock_flag  = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_generateproof_hls_deadlock_reporter.sv
`default_nettype none
// Self-checking bench for generateproof_hls_deadlock_reporter (default parameters).
module tb_generateproof_hls_deadlock_reporter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mon_block;
   logic [7:0]  axis_block_sigs;
   logic [18:0] inst_idle_sigs;
   logic [10:0] inst_block_sigs;
   logic        clear;
   logic        rpt_ready;
   logic        rpt_valid;
   logic [0:0]  rpt_mon_id;
   logic [7:0]  rpt_axis;
   logic [18:0] rpt_idle;
   logic [10:0] rpt_inst_block;
   logic [15:0] rpt_count;
   logic        deadlock_flag;
`ifdef GENERATEPROOF_DEADLOCK_TIMESTAMP_EN
   logic [31:0] rpt_timestamp;
`endif

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   generateproof_hls_deadlock_reporter dut (
      .clock           (clk),
      .reset           (reset),
      .mon_block       (mon_block),
      .axis_block_sigs (axis_block_sigs),
      .inst_idle_sigs  (inst_idle_sigs),
      .inst_block_sigs (inst_block_sigs),
      .clear           (clear),
      .rpt_valid       (rpt_valid),
      .rpt_ready       (rpt_ready),
      .rpt_mon_id      (rpt_mon_id),
      .rpt_axis        (rpt_axis),
      .rpt_idle        (rpt_idle),
      .rpt_inst_block  (rpt_inst_block),
      .rpt_count       (rpt_count),
`ifdef GENERATEPROOF_DEADLOCK_TIMESTAMP_EN
      .rpt_timestamp   (rpt_timestamp),
`endif
      .deadlock_flag   (deadlock_flag)
   );

   typedef struct {
      logic [1:0]  mon;
      logic [7:0]  axis;
      logic [18:0] idle;
      logic [10:0] blk;
      int          n;
      logic        exp_valid;
      logic        exp_id;
      logic [7:0]  exp_axis;
      logic [18:0] exp_idle;
      logic [10:0] exp_blk;
      logic        exp_flag;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      mon_block       = '0;
      clear           = 1'b0;
      rpt_ready       = 1'b0;
      axis_block_sigs = '0;
      inst_idle_sigs  = '0;
      inst_block_sigs = '0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{2'b10, 8'h18, 19'h12345, 11'h021, 16, 1'b1, 1'b1, 8'h18, 19'h12345, 11'h021, 1'b1};
      vecs[1] = '{2'b01, 8'h33, 19'h00F0F, 11'h111, 15, 1'b0, 1'b0, 8'h00, 19'h00000, 11'h000, 1'b0};
      vecs[2] = '{2'b11, 8'hA5, 19'h7FFFF, 11'h7FF, 16, 1'b1, 1'b0, 8'hA5, 19'h7FFFF, 11'h7FF, 1'b1};
      vecs[3] = '{2'b01, 8'h5A, 19'h40001, 11'h400, 20, 1'b1, 1'b0, 8'h5A, 19'h40001, 11'h400, 1'b1};
      vecs[4] = '{2'b00, 8'hFF, 19'h7FFFF, 11'h7FF, 30, 1'b0, 1'b0, 8'h00, 19'h00000, 11'h000, 1'b0};
      vecs[5] = '{2'b10, 8'h77, 19'h00077, 11'h077, 1,  1'b0, 1'b0, 8'h00, 19'h00000, 11'h000, 1'b0};

      // Reset state
      do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_valid", 32'(rpt_valid), 32'd0);
      chk("reset_count", 32'(rpt_count), 32'd0);
      chk("reset_flag",  32'(deadlock_flag), 32'd0);
      chk("reset_axis",  32'(rpt_axis), 32'd0);

      // Persistence/glitch table: hold inputs for n edges from a fresh reset
      for (int v = 0; v < 6; v++) begin
         do_reset();
         mon_block       = vecs[v].mon;
         axis_block_sigs = vecs[v].axis;
         inst_idle_sigs  = vecs[v].idle;
         inst_block_sigs = vecs[v].blk;
         repeat (vecs[v].n) step();
         chk($sformatf("vec%0d_valid", v), 32'(rpt_valid),      32'(vecs[v].exp_valid));
         chk($sformatf("vec%0d_id", v),    32'(rpt_mon_id),     32'(vecs[v].exp_id));
         chk($sformatf("vec%0d_axis", v),  32'(rpt_axis),       32'(vecs[v].exp_axis));
         chk($sformatf("vec%0d_idle", v),  32'(rpt_idle),       32'(vecs[v].exp_idle));
         chk($sformatf("vec%0d_blk", v),   32'(rpt_inst_block), 32'(vecs[v].exp_blk));
         chk($sformatf("vec%0d_flag", v),  32'(deadlock_flag),  32'(vecs[v].exp_flag));
         chk($sformatf("vec%0d_count", v), 32'(rpt_count),      32'd0);
      end

      // Glitch: after the 15-edge burst drops, the next 16-edge burst must be needed in full
      do_reset();
      mon_block = 2'b01;
      repeat (15) step();
      mon_block = 2'b00;
      step();
      mon_block = 2'b01;
      repeat (15) step();
      chk("glitch_no_early", 32'(rpt_valid), 32'd0);
      step();
      chk("glitch_refire", 32'(rpt_valid), 32'd1);

      // Backpressure with changing live inputs, then handshake
      do_reset();
      mon_block       = 2'b01;
      axis_block_sigs = 8'h18;
      inst_block_sigs = 11'h021;
      repeat (16) step();
      chk("bp_valid", 32'(rpt_valid), 32'd1);
      for (int c = 0; c < 10; c++) begin
         axis_block_sigs = 8'(8'hE0 + c);
         inst_block_sigs = 11'h3FF;
         step();
         chk("bp_hold_valid", 32'(rpt_valid), 32'd1);
         chk("bp_hold_axis",  32'(rpt_axis),  32'h18);
      end
      chk("bp_hold_blk", 32'(rpt_inst_block), 32'h021);
      rpt_ready = 1'b1;
      step();
      rpt_ready = 1'b0;
      chk("bp_hs_valid", 32'(rpt_valid), 32'd0);
      chk("bp_hs_count", 32'(rpt_count), 32'd1);

      // No re-report while the same monitor stays blocked
      for (int c = 0; c < 100; c++) begin
         step();
         if (rpt_valid !== 1'b0) chk("norerpt_valid", 32'(rpt_valid), 32'd0);
      end
      chk("norerpt_final", 32'(rpt_valid), 32'd0);
      mon_block = 2'b00;
      step();
      mon_block = 2'b01;
      repeat (16) step();
      chk("rerpt_valid", 32'(rpt_valid), 32'd1);
      rpt_ready = 1'b1;
      step();
      rpt_ready = 1'b0;
      chk("rerpt_count", 32'(rpt_count), 32'd2);
      chk("rerpt_flag",  32'(deadlock_flag), 32'd1);

      // Clear ignored in CONFIRM, honoured in HOLD
      do_reset();
      mon_block = 2'b10;
      repeat (16) step();
      clear = 1'b1;
      step();
      chk("clr_confirm_valid", 32'(rpt_valid), 32'd1);
      chk("clr_confirm_flag",  32'(deadlock_flag), 32'd1);
      rpt_ready = 1'b1;
      step();
      rpt_ready = 1'b0;
      chk("clr_hs_valid", 32'(rpt_valid), 32'd0);
      chk("clr_hs_count", 32'(rpt_count), 32'd1);
      chk("clr_hs_flag",  32'(deadlock_flag), 32'd1);
      step();
      clear = 1'b0;
      chk("clr_hold_flag",  32'(deadlock_flag), 32'd0);
      chk("clr_hold_count", 32'(rpt_count), 32'd1);
      repeat (15) step();
      chk("clr_idle_early", 32'(rpt_valid), 32'd0);
      step();
      chk("clr_idle_fire", 32'(rpt_valid), 32'd1);

      // Reset in CONFIRM with rpt_valid high
      reset = 1'b1;
      step();
      reset = 1'b0;
      mon_block = 2'b00;
      chk("rst_cf_valid", 32'(rpt_valid), 32'd0);
      chk("rst_cf_count", 32'(rpt_count), 32'd0);
      chk("rst_cf_axis",  32'(rpt_axis), 32'd0);
      chk("rst_cf_id",    32'(rpt_mon_id), 32'd0);
      chk("rst_cf_flag",  32'(deadlock_flag), 32'd0);

      // Clear beats mon_block in IDLE; clear in ARM restarts persistence
      do_reset();
      mon_block = 2'b01;
      clear     = 1'b1;
      step();
      clear = 1'b0;
      repeat (15) step();
      chk("clr_idle_prio_early", 32'(rpt_valid), 32'd0);
      step();
      chk("clr_idle_prio_fire", 32'(rpt_valid), 32'd1);
      do_reset();
      mon_block = 2'b01;
      repeat (10) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      repeat (15) step();
      chk("clr_arm_early", 32'(rpt_valid), 32'd0);
      step();
      chk("clr_arm_fire", 32'(rpt_valid), 32'd1);

`ifdef GENERATEPROOF_DEADLOCK_TIMESTAMP_EN
      // First block sampled when the timestamp reads 22 confirms at 37
      do_reset();
      repeat (22) step();
      mon_block = 2'b01;
      repeat (16) step();
      chk("ts_valid", 32'(rpt_valid), 32'd1);
      chk("ts_value", rpt_timestamp, 32'd37);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/generateproof_hls_deadlock_reporter.md
Name: generateproof_hls_deadlock_reporter

Overview:
- Top-level consumer of the per-instance deadlock monitor `block` outputs in the GenerateProof HLS design.
- Confirms that a block condition persists, then snapshots the axis and instance block/idle vectors.
- Presents a single report record over a valid/ready handshake to the debug/status logic, and keeps a sticky deadlock flag plus a saturating report counter.

Parameters:
- NUM_MON, 2: number of monitor `block` inputs.
- AXIS_W, 8: width of axis_block_sigs.
- IDLE_W, 19: width of inst_idle_sigs.
- BLOCK_W, 11: width of inst_block_sigs.
- CONFIRM_CYCLES, 16: consecutive sampled-high cycles needed to confirm; legal range 2..65535.
- TS_W, 32: timestamp width (optional feature only).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- mon_block  in  NUM_MON  registered `block` outputs of the deadlock monitors.
- axis_block_sigs  in  AXIS_W  live axis block vector.
- inst_idle_sigs  in  IDLE_W  live instance idle vector.
- inst_block_sigs  in  BLOCK_W  live instance block vector.
- clear  in  1  software clear of the sticky flag and return to IDLE.
- rpt_valid  out  1  report record valid.
- rpt_ready  in  1  report consumer ready.
- rpt_mon_id  out  max(1,clog2(NUM_MON))  index of the confirmed monitor.
- rpt_axis  out  AXIS_W  snapshot of axis_block_sigs.
- rpt_idle  out  IDLE_W  snapshot of inst_idle_sigs.
- rpt_inst_block  out  BLOCK_W  snapshot of inst_block_sigs.
- rpt_count  out  16  number of accepted reports, saturating.
- deadlock_flag  out  1  sticky: set on confirmation.

Behaviour:
- Reset values:
  - Outputs: rpt_valid=0, every payload output=0, rpt_count=0, deadlock_flag=0.
  - Internal: FSM=IDLE, persistence counter=0.
- FSM states: IDLE, ARM, CONFIRM, HOLD.
- IDLE:
  - If any mon_block bit is high, latch the lowest set index as cand_id, load counter=1, go to ARM.
- ARM:
  - If mon_block[cand_id]=1: increment the counter.
  - When the counter equals CONFIRM_CYCLES-1 and mon_block[cand_id]=1 at the same edge:
    - capture rpt_axis, rpt_idle and rpt_inst_block from the live inputs at that edge;
    - set rpt_mon_id=cand_id;
    - set deadlock_flag=1;
    - go to CONFIRM.
  - If mon_block[cand_id]=0: counter=0, go to IDLE. Other monitors are not considered in that cycle.
  - Other mon_block bits never change cand_id while in ARM.
- Latency: mon_block[i] sampled high on CONFIRM_CYCLES consecutive edges gives rpt_valid=1 in the cycle after the last of those edges.
- CONFIRM:
  - rpt_valid=1; payload held stable.
  - rpt_valid never drops before the handshake; the mon_block inputs are ignored.
  - On rpt_valid & rpt_ready: rpt_valid=0 next cycle, rpt_count += 1 (saturates at 16'hFFFF, no wrap), go to HOLD.
- HOLD:
  - Waits for mon_block == 0 (all bits) on one edge, then goes to IDLE.
  - This prevents re-reporting the same stuck condition.
  - Payload outputs keep their last values until the next capture.
- clear:
  - Honoured in IDLE, ARM and HOLD: deadlock_flag=0, counter=0, go to IDLE next cycle. rpt_count is unaffected.
  - In CONFIRM, clear is ignored, so a pending report is never dropped.
  - When clear and mon_block are both high in IDLE, clear wins and ARM is not entered that cycle.
- Reset mid-operation (including CONFIRM with rpt_valid=1): all state returns to reset values next edge. Dropping rpt_valid here is permitted.
- The counter is 16 bits; it never exceeds CONFIRM_CYCLES-1.

Optional Feature:
- Macro: GENERATEPROOF_DEADLOCK_TIMESTAMP_EN.
- When defined:
  - A free-running TS_W-bit cycle counter is added. It is cleared by reset, wraps modulo 2^TS_W, and is unaffected by clear.
  - An output port rpt_timestamp[TS_W-1:0] is added. It is captured at the same edge as the other snapshot fields, holding the counter value at that edge.
- When undefined: neither the counter nor the port exists, and all other behaviour is identical.

Test Plan:
- Persistence confirm: CONFIRM_CYCLES=16, mon_block[1]=1 for 16 edges, axis=8'h18, inst_block=11'h021 -> rpt_valid=1 on the next cycle; rpt_mon_id=1, rpt_axis=8'h18, rpt_inst_block=11'h021, deadlock_flag=1.
- Glitch reject: mon_block[0] high for 15 edges then low -> no rpt_valid; FSM back to IDLE; deadlock_flag=0.
- Backpressure: confirm, then hold rpt_ready=0 for 10 cycles while axis_block_sigs changes -> rpt_valid stays 1 and payload is unchanged. rpt_ready=1 -> rpt_count=1, rpt_valid=0 next cycle.
- No re-report: after handshake keep mon_block[0]=1 for 100 cycles -> no new report. Drop it for 1 cycle, then reassert for 16 -> second report, rpt_count=2.
- Clear priority: clear during CONFIRM -> ignored, report still delivered. Clear in HOLD -> deadlock_flag=0, FSM=IDLE, rpt_count unchanged.
- Reset in CONFIRM with rpt_valid=1 -> next cycle rpt_valid=0, rpt_count=0, payload=0. With the optional feature enabled, rpt_timestamp equals the counter value at the capture edge, e.g. 37 for a first block at cycle 22.
